fft_config_sink: RTL and testbench

//  Receive side of the FFT single-beat AXI-Stream config channel. Accepts a 16-bit word
//  {7'b0, scale_sch[7:0], forward}, holds it until the FFT datapath is idle between frames,

---
 rtl/fft_config_sink.sv | 101 ++++++++++
 tb/tb_fft_config_sink.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_config_sink.sv
// Single-beat config sink: parks one word in a pending register until frame_busy is low, then applies it.
// Apply lands one edge after acceptance at the earliest; s_tready is low while a word is pending.
module fft_config_sink #(
  parameter logic [7:0] DEFAULT_SCALE = 8'hAA,
  parameter logic       DEFAULT_FWD   = 1'b1,
  parameter int         CNT_W         = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  input  logic [15:0]      s_tdata,
  input  logic             frame_busy,
  output logic [7:0]       cfg_scale_sch,
  output logic             cfg_forward,
  output logic             cfg_valid,
  output logic             cfg_update,
  output logic             evt_reserved_err,
  output logic             evt_tlast_err,
  output logic [CNT_W-1:0] cfg_count
);

  typedef struct packed {
    logic [7:0] scale_sch;
    logic       forward;
  } cfg_t;

  typedef enum logic {
    ST_ACCEPT  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state;
  state_t state_nxt;
  cfg_t   pending_cfg;
  cfg_t   active_cfg;
  cfg_t   word_cfg;
  logic   hs;
  logic   rsvd_bad;
  logic   take_word;
  logic   do_apply;

  assign word_cfg = cfg_t'(s_tdata[8:0]);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_ACCEPT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACCEPT:  if (take_word)   state_nxt = ST_PENDING;
      ST_PENDING: if (!frame_busy) state_nxt = ST_ACCEPT;
      default:                     state_nxt = ST_ACCEPT;
    endcase
  end

  // Ready comes from the state register alone, never from s_tvalid.
  always_comb begin
    s_tready  = resetn && (state == ST_ACCEPT);
    hs        = s_tvalid && s_tready;
    rsvd_bad  = |s_tdata[15:9];
    take_word = hs && !rsvd_bad;
    do_apply  = (state == ST_PENDING) && !frame_busy;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending_cfg      <= '0;
      active_cfg       <= '{DEFAULT_SCALE, DEFAULT_FWD};
      cfg_valid        <= 1'b0;
      cfg_update       <= 1'b0;
      evt_reserved_err <= 1'b0;
      evt_tlast_err    <= 1'b0;
      cfg_count        <= '0;
    end else begin
      cfg_update       <= do_apply;
      evt_reserved_err <= hs && rsvd_bad;
      evt_tlast_err    <= take_word && !s_tlast;
      if (take_word) begin
        pending_cfg <= word_cfg;
      end
      if (do_apply) begin
        active_cfg <= pending_cfg;
        cfg_valid  <= 1'b1;
        cfg_count  <= cfg_count + CNT_ONE;
      end
    end
  end

  assign cfg_scale_sch = active_cfg.scale_sch;
  assign cfg_forward   = active_cfg.forward;

endmodule

// File: tb/tb_fft_config_sink.sv
// Bench for fft_config_sink: directed vector table with hand-derived expectations,
// then random traffic checked every cycle against a queue-based reference model.
module tb_fft_config_sink;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [15:0] s_tdata;
  logic        frame_busy;
  logic [7:0]  cfg_scale_sch;
  logic        cfg_forward;
  logic        cfg_valid;
  logic        cfg_update;
  logic        evt_reserved_err;
  logic        evt_tlast_err;
  logic [15:0] cfg_count;

  always #5 clk = ~clk;

  fft_config_sink #(
    .DEFAULT_SCALE(8'hAA),
    .DEFAULT_FWD  (1'b1),
    .CNT_W        (16)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .s_tvalid        (s_tvalid),
    .s_tready        (s_tready),
    .s_tlast         (s_tlast),
    .s_tdata         (s_tdata),
    .frame_busy      (frame_busy),
    .cfg_scale_sch   (cfg_scale_sch),
    .cfg_forward     (cfg_forward),
    .cfg_valid       (cfg_valid),
    .cfg_update      (cfg_update),
    .evt_reserved_err(evt_reserved_err),
    .evt_tlast_err   (evt_tlast_err),
    .cfg_count       (cfg_count)
  );

  typedef struct packed {
    logic [7:0]  scale;
    logic        fwd;
    logic        cv;
    logic        upd;
    logic        rerr;
    logic        terr;
    logic [15:0] cnt;
    logic        rdy;
  } outs_t;

  typedef struct {
    logic        rst;
    logic        v;
    logic        l;
    logic [15:0] d;
    logic        b;
    int          rep;
    outs_t       exp;
  } vec_t;

  typedef struct packed {
    logic [7:0] scale;
    logic       fwd;
  } word_t;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: at most one word waits in a queue; outputs follow the behavioural rules.
  word_t       m_q[$];
  logic [7:0]  m_scale = 8'hAA;
  logic        m_fwd = 1'b1;
  logic        m_cv = 1'b0;
  logic        m_upd = 1'b0;
  logic        m_rerr = 1'b0;
  logic        m_terr = 1'b0;
  int          m_cnt = 0;

  function automatic outs_t dut_outs();
    outs_t o;
    o.scale = cfg_scale_sch;
    o.fwd   = cfg_forward;
    o.cv    = cfg_valid;
    o.upd   = cfg_update;
    o.rerr  = evt_reserved_err;
    o.terr  = evt_tlast_err;
    o.cnt   = cfg_count;
    o.rdy   = s_tready;
    return o;
  endfunction

  function automatic outs_t model_outs();
    outs_t o;
    o.scale = m_scale;
    o.fwd   = m_fwd;
    o.cv    = m_cv;
    o.upd   = m_upd;
    o.rerr  = m_rerr;
    o.terr  = m_terr;
    o.cnt   = 16'(m_cnt);
    o.rdy   = resetn && (m_q.size() == 0);
    return o;
  endfunction

  task automatic model_edge();
    word_t w;
    if (!resetn) begin
      m_q.delete();
      m_scale = 8'hAA;
      m_fwd   = 1'b1;
      m_cv    = 1'b0;
      m_upd   = 1'b0;
      m_rerr  = 1'b0;
      m_terr  = 1'b0;
      m_cnt   = 0;
    end else begin
      m_upd  = 1'b0;
      m_rerr = 1'b0;
      m_terr = 1'b0;
      if (m_q.size() == 0) begin
        if (s_tvalid) begin
          if ((s_tdata >> 9) != 0) begin
            m_rerr = 1'b1;
          end else begin
            w.scale = 8'((s_tdata >> 1) & 16'h00FF);
            w.fwd   = s_tdata[0];
            m_q.push_back(w);
            m_terr = !s_tlast;
          end
        end
      end else if (!frame_busy) begin
        w       = m_q.pop_front();
        m_scale = w.scale;
        m_fwd   = w.fwd;
        m_cv    = 1'b1;
        m_upd   = 1'b1;
        m_cnt   = (m_cnt + 1) % 65536;
      end
    end
  endtask

  task automatic check(input string nm, input outs_t exp);
    outs_t act;
    act = dut_outs();
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got scale=%h fwd=%b cv=%b upd=%b rerr=%b terr=%b cnt=%0d rdy=%b want scale=%h fwd=%b cv=%b upd=%b rerr=%b terr=%b cnt=%0d rdy=%b",
               nm, $time, act.scale, act.fwd, act.cv, act.upd, act.rerr, act.terr, act.cnt, act.rdy,
               exp.scale, exp.fwd, exp.cv, exp.upd, exp.rerr, exp.terr, exp.cnt, exp.rdy);
    end
  endtask

  task automatic tick(input string nm);
    @(posedge clk);
    model_edge();
    #1;
    check(nm, model_outs());
  endtask

  function automatic vec_t mk(input logic rst, input logic v, input logic l, input logic [15:0] d,
                              input logic b, input int rep, input logic [7:0] scale, input logic fwd,
                              input logic cv, input logic upd, input logic rerr, input logic terr,
                              input int cnt, input logic rdy);
    vec_t r;
    r.rst = rst; r.v = v; r.l = l; r.d = d; r.b = b; r.rep = rep;
    r.exp.scale = scale; r.exp.fwd = fwd; r.exp.cv = cv; r.exp.upd = upd;
    r.exp.rerr = rerr; r.exp.terr = terr; r.exp.cnt = 16'(cnt); r.exp.rdy = rdy;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    resetn     = 1'b0;
    s_tvalid   = 1'b0;
    s_tlast    = 1'b0;
    s_tdata    = 16'h0000;
    frame_busy = 1'b0;

    //              rst v  l  data      b  rep  scale  fwd cv upd re te cnt rdy
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 2,  8'hAA, 1,  0, 0,  0, 0, 0,  0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 5,  8'hAA, 1,  0, 0,  0, 0, 0,  1));
    tbl.push_back(mk(1, 1, 1, 16'h0133, 0, 1,  8'hAA, 1,  0, 0,  0, 0, 0,  0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1,  8'h99, 1,  1, 1,  0, 0, 1,  1));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1,  8'h99, 1,  1, 0,  0, 0, 1,  1));
    tbl.push_back(mk(1, 1, 1, 16'h0002, 1, 1,  8'h99, 1,  1, 0,  0, 0, 1,  0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 10, 8'h99, 1,  1, 0,  0, 0, 1,  0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1,  8'h01, 0,  1, 1,  0, 0, 2,  1));
    tbl.push_back(mk(1, 1, 1, 16'h8133, 0, 1,  8'h01, 0,  1, 0,  1, 0, 2,  1));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1,  8'h01, 0,  1, 0,  0, 0, 2,  1));
    tbl.push_back(mk(1, 1, 0, 16'h00FE, 0, 1,  8'h01, 0,  1, 0,  0, 1, 2,  0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1,  8'h7F, 0,  1, 1,  0, 0, 3,  1));
    // word parked by frame_busy, then reset discards it
    tbl.push_back(mk(1, 1, 1, 16'h0133, 1, 1,  8'h7F, 0,  1, 0,  0, 0, 3,  0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 1,  8'h7F, 0,  1, 0,  0, 0, 3,  0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 1,  8'hAA, 1,  0, 0,  0, 0, 0,  0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 3,  8'hAA, 1,  0, 0,  0, 0, 0,  1));
    // back-to-back valid: one accept every two cycles
    tbl.push_back(mk(1, 1, 1, 16'h0004, 0, 1,  8'hAA, 1,  0, 0,  0, 0, 0,  0));
    tbl.push_back(mk(1, 1, 1, 16'h0004, 0, 1,  8'h02, 0,  1, 1,  0, 0, 1,  1));
    tbl.push_back(mk(1, 1, 1, 16'h0007, 0, 1,  8'h02, 0,  1, 0,  0, 0, 1,  0));
    tbl.push_back(mk(1, 1, 1, 16'h0007, 0, 1,  8'h03, 1,  1, 1,  0, 0, 2,  1));
    tbl.push_back(mk(1, 1, 1, 16'h0200, 0, 1,  8'h03, 1,  1, 0,  1, 0, 2,  1));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1,  8'h03, 1,  1, 0,  0, 0, 2,  1));
    // same value reapplied still pulses cfg_update
    tbl.push_back(mk(1, 1, 1, 16'h0007, 0, 1,  8'h03, 1,  1, 0,  0, 0, 2,  0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1,  8'h03, 1,  1, 1,  0, 0, 3,  1));
    // frame_busy is ignored while accepting
    tbl.push_back(mk(1, 1, 1, 16'h0004, 1, 1,  8'h03, 1,  1, 0,  0, 0, 3,  0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1,  8'h02, 0,  1, 1,  0, 0, 4,  1));

    #2;
    for (int i = 0; i < tbl.size(); i++) begin
      resetn     = tbl[i].rst;
      s_tvalid   = tbl[i].v;
      s_tlast    = tbl[i].l;
      s_tdata    = tbl[i].d;
      frame_busy = tbl[i].b;
      for (int k = 0; k < tbl[i].rep; k++) begin
        tick($sformatf("model_row%0d", i));
        check($sformatf("row%0d_c%0d", i, k), tbl[i].exp);
      end
    end

    for (int c = 0; c < 3000; c++) begin
      resetn     = ($urandom_range(0, 99) != 0);
      s_tvalid   = ($urandom_range(0, 2) != 0);
      s_tlast    = ($urandom_range(0, 3) != 0);
      s_tdata    = ($urandom_range(0, 4) == 0) ? 16'($urandom) : {7'b0, 9'($urandom)};
      frame_busy = ($urandom_range(0, 2) == 0);
      tick($sformatf("rand%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
